// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter.
// Groups three sides of the shared RAM port:
//   core_*  : core load/store path (request in, read data and stall out)
//   aux_*   : auxiliary requester (request/grant, registered read data, error pulse)
//   mem_*   : single data RAM port (combinational read on mem_load)
// Modports:
//   slave   : the arbiter's view
//   master  : the surrounding system's view (drives core/aux requests and mem_load)
interface dmem_arbiter_if;
    logic       core_en_load;
    logic       core_en_store;
    logic [9:0] core_addr;
    logic [7:0] core_store;
    logic [7:0] core_load;
    logic       core_stall;

    logic       aux_req;
    logic       aux_we;
    logic [9:0] aux_addr;
    logic [7:0] aux_wdata;
    logic       aux_gnt;
    logic [7:0] aux_rdata;
    logic       aux_rvalid;
    logic       aux_err;

    logic       mem_en_load;
    logic       mem_en_store;
    logic [9:0] mem_addr;
    logic [7:0] mem_store;
    logic [7:0] mem_load;

    modport slave (
        input  core_en_load, core_en_store, core_addr, core_store,
        output core_load, core_stall,
        input  aux_req, aux_we, aux_addr, aux_wdata,
        output aux_gnt, aux_rdata, aux_rvalid, aux_err,
        output mem_en_load, mem_en_store, mem_addr, mem_store,
        input  mem_load
    );

    modport master (
        output core_en_load, core_en_store, core_addr, core_store,
        input  core_load, core_stall,
        output aux_req, aux_we, aux_addr, aux_wdata,
        input  aux_gnt, aux_rdata, aux_rvalid, aux_err,
        input  mem_en_load, mem_en_store, mem_addr, mem_store,
        output mem_load
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the core load/store path and an aux requester.
// The core has default priority; aux is granted combinationally on idle core
// cycles, and after STARVE_MAX consecutive ungranted cycles aux takes the port
// for up to BURST_MAX cycles while the core is stalled.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : dmem_arbiter_if.slave (core_*, aux_*, mem_* signals)
// Optional feature macro DMEM_ARB_PROTECT_EN: aux stores at or above PROT_BASE
// are granted but blocked from the RAM, and aux_err pulses the following cycle.
//
// state  | meaning
// S_CORE | core owns the port; aux served only on idle core cycles
// S_AUX  | forced aux burst; core stalled
module dmem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned BURST_MAX  = 2
`ifdef DMEM_ARB_PROTECT_EN
    ,
    parameter logic [9:0]  PROT_BASE  = 10'h300
`endif
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic {S_CORE, S_AUX} state_t;

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic [7:0] aux_rdata_q, aux_rdata_d;
    logic       aux_rvalid_q, aux_rvalid_d;

    logic       core_act;
    logic       aux_sel;
    logic       aux_gnt_c;
    logic       core_stall_c;
    logic       aux_blocked;
    logic       starve_hit;
    logic       burst_hit;
    logic [3:0] wait_inc;
    logic [3:0] burst_inc;

    assign core_act  = bus.core_en_load | bus.core_en_store;
    assign wait_inc  = (wait_cnt_q == 4'hF) ? 4'hF : wait_cnt_q + 4'd1;
    assign burst_inc = (burst_cnt_q == 4'hF) ? 4'hF : burst_cnt_q + 4'd1;
    // Compare in 5 bits so the +1 can never wrap into a false match.
    assign starve_hit = ({1'b0, wait_cnt_q} + 5'd1) == 5'(STARVE_MAX);
    assign burst_hit  = ({1'b0, burst_cnt_q} + 5'd1) == 5'(BURST_MAX);

`ifdef DMEM_ARB_PROTECT_EN
    logic aux_err_q, aux_err_d;
    assign aux_blocked = bus.aux_we && (bus.aux_addr >= PROT_BASE);
`else
    assign aux_blocked = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        aux_sel      = 1'b0;
        aux_gnt_c    = 1'b0;
        core_stall_c = 1'b0;
        case (state_q)
            S_CORE: begin
                if (core_act) begin
                    if (bus.aux_req) begin
                        wait_cnt_d = wait_inc;
                        if (starve_hit) begin
                            state_d     = S_AUX;
                            burst_cnt_d = 4'd0;
                        end
                    end else begin
                        wait_cnt_d = 4'd0;
                    end
                end else begin
                    // Idle core cycle: hand the port to aux without a state change.
                    aux_sel    = bus.aux_req;
                    aux_gnt_c  = bus.aux_req;
                    wait_cnt_d = 4'd0;
                end
            end
            S_AUX: begin
                core_stall_c = 1'b1;
                aux_sel      = 1'b1;
                aux_gnt_c    = bus.aux_req;
                wait_cnt_d   = 4'd0;
                burst_cnt_d  = burst_inc;
                if (!bus.aux_req || burst_hit) begin
                    state_d = S_CORE;
                end
            end
            default: state_d = S_CORE;
        endcase
    end

    always_comb begin
        aux_rvalid_d = aux_gnt_c && !bus.aux_we;
        aux_rdata_d  = aux_rvalid_d ? bus.mem_load : aux_rdata_q;
    end

`ifdef DMEM_ARB_PROTECT_EN
    always_comb begin
        aux_err_d = aux_gnt_c && aux_blocked;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_CORE;
            wait_cnt_q   <= 4'd0;
            burst_cnt_q  <= 4'd0;
            aux_rdata_q  <= 8'd0;
            aux_rvalid_q <= 1'b0;
`ifdef DMEM_ARB_PROTECT_EN
            aux_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            aux_rdata_q  <= aux_rdata_d;
            aux_rvalid_q <= aux_rvalid_d;
`ifdef DMEM_ARB_PROTECT_EN
            aux_err_q    <= aux_err_d;
`endif
        end
    end

    // RAM port mux. Core enables pass through untouched, even if both are set.
    always_comb begin
        if (aux_sel) begin
            bus.mem_addr     = bus.aux_addr;
            bus.mem_store    = bus.aux_wdata;
            bus.mem_en_load  = bus.aux_req && !bus.aux_we;
            bus.mem_en_store = bus.aux_req && bus.aux_we && !aux_blocked;
        end else begin
            bus.mem_addr     = bus.core_addr;
            bus.mem_store    = bus.core_store;
            bus.mem_en_load  = bus.core_en_load;
            bus.mem_en_store = bus.core_en_store;
        end
    end

    assign bus.core_load  = bus.mem_load;
    assign bus.core_stall = core_stall_c;
    assign bus.aux_gnt    = aux_gnt_c;
    assign bus.aux_rdata  = aux_rdata_q;
    assign bus.aux_rvalid = aux_rvalid_q;
`ifdef DMEM_ARB_PROTECT_EN
    assign bus.aux_err    = aux_err_q;
`else
    assign bus.aux_err    = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    localparam int STARVE_MAX = 4;
    localparam int BURST_MAX  = 2;
    localparam logic [9:0] PROT_BASE = 10'h300;

    logic clk = 1'b0;
    logic rst;
    int checks   = 0;
    int failures = 0;

    dmem_arbiter_if bus();
    logic [7:0] ram [0:1023];

    always #5 clk = ~clk;

    assign bus.mem_load = ram[bus.mem_addr];
    always @(posedge clk) if (bus.mem_en_store) ram[bus.mem_addr] <= bus.mem_store;

    dmem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.core_en_load  = 1'b0;
        bus.core_en_store = 1'b0;
        bus.core_addr     = 10'h0;
        bus.core_store    = 8'h0;
        bus.aux_req       = 1'b0;
        bus.aux_we        = 1'b0;
        bus.aux_addr      = 10'h0;
        bus.aux_wdata     = 8'h0;
    endtask

    task automatic core_write(input logic [9:0] a, input logic [7:0] d);
        set_idle();
        bus.core_en_store = 1'b1;
        bus.core_addr     = a;
        bus.core_store    = d;
        step();
        set_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.core_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.core_stall); end
        checks++; if (bus.aux_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", bus.aux_gnt); end
        checks++; if (bus.aux_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", bus.aux_rvalid); end
        checks++; if ({bus.mem_en_load, bus.mem_en_store} !== 2'b00) begin failures++; $display("FAIL reset_mem_en got=%b exp=00", {bus.mem_en_load, bus.mem_en_store}); end
        checks++; if (bus.aux_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", bus.aux_rdata); end
        checks++; if (bus.aux_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.aux_err); end
        step();
    endtask

    task automatic test_core_only();
        set_idle();
        bus.core_en_store = 1'b1;
        bus.core_addr     = 10'h005;
        bus.core_store    = 8'hA5;
        @(negedge clk);
        checks++; if ({bus.mem_en_load, bus.mem_en_store} !== 2'b01) begin failures++; $display("FAIL core_st_en got=%b exp=01", {bus.mem_en_load, bus.mem_en_store}); end
        checks++; if (bus.mem_addr !== 10'h005) begin failures++; $display("FAIL core_st_addr got=%h exp=005", bus.mem_addr); end
        checks++; if (bus.mem_store !== 8'hA5) begin failures++; $display("FAIL core_st_data got=%h exp=a5", bus.mem_store); end
        checks++; if (bus.core_stall !== 1'b0) begin failures++; $display("FAIL core_st_stall got=%b exp=0", bus.core_stall); end
        step();
        set_idle();
        bus.core_en_load = 1'b1;
        bus.core_addr    = 10'h005;
        @(negedge clk);
        checks++; if (bus.core_load !== 8'hA5) begin failures++; $display("FAIL core_ld_data got=%h exp=a5", bus.core_load); end
        checks++; if ({bus.mem_en_load, bus.mem_en_store} !== 2'b10) begin failures++; $display("FAIL core_ld_en got=%b exp=10", {bus.mem_en_load, bus.mem_en_store}); end
        checks++; if (bus.core_stall !== 1'b0) begin failures++; $display("FAIL core_ld_stall got=%b exp=0", bus.core_stall); end
        step();
        // Both enables from the core pass straight through.
        bus.core_en_store = 1'b1;
        bus.core_addr     = 10'h006;
        bus.core_store    = 8'h5A;
        @(negedge clk);
        checks++; if ({bus.mem_en_load, bus.mem_en_store} !== 2'b11) begin failures++; $display("FAIL core_both_en got=%b exp=11", {bus.mem_en_load, bus.mem_en_store}); end
        step();
        set_idle();
    endtask

    task automatic test_opportunistic();
        core_write(10'h010, 8'h3C);
        bus.aux_req  = 1'b1;
        bus.aux_we   = 1'b0;
        bus.aux_addr = 10'h010;
        @(negedge clk);
        checks++; if (bus.aux_gnt !== 1'b1) begin failures++; $display("FAIL opp_gnt got=%b exp=1", bus.aux_gnt); end
        checks++; if ({bus.mem_en_load, bus.mem_en_store} !== 2'b10) begin failures++; $display("FAIL opp_en got=%b exp=10", {bus.mem_en_load, bus.mem_en_store}); end
        checks++; if (bus.mem_addr !== 10'h010) begin failures++; $display("FAIL opp_addr got=%h exp=010", bus.mem_addr); end
        checks++; if (bus.core_stall !== 1'b0) begin failures++; $display("FAIL opp_stall got=%b exp=0", bus.core_stall); end
        step();
        set_idle();
        @(negedge clk);
        checks++; if (bus.aux_rvalid !== 1'b1) begin failures++; $display("FAIL opp_rvalid got=%b exp=1", bus.aux_rvalid); end
        checks++; if (bus.aux_rdata !== 8'h3C) begin failures++; $display("FAIL opp_rdata got=%h exp=3c", bus.aux_rdata); end
        step();
        @(negedge clk);
        checks++; if (bus.aux_rvalid !== 1'b0) begin failures++; $display("FAIL opp_rvalid_once got=%b exp=0", bus.aux_rvalid); end
        step();
    endtask

    task automatic test_back_to_back();
        core_write(10'h040, 8'h11);
        core_write(10'h041, 8'h22);
        bus.aux_req = 1'b1; bus.aux_we = 1'b0; bus.aux_addr = 10'h040;
        step();
        bus.aux_addr = 10'h041;
        @(negedge clk);
        checks++; if (bus.aux_rvalid !== 1'b1 || bus.aux_rdata !== 8'h11) begin failures++; $display("FAIL b2b_first got=%b/%h exp=1/11", bus.aux_rvalid, bus.aux_rdata); end
        step();
        bus.aux_we = 1'b1; bus.aux_addr = 10'h050; bus.aux_wdata = 8'h77;
        @(negedge clk);
        checks++; if (bus.aux_rvalid !== 1'b1 || bus.aux_rdata !== 8'h22) begin failures++; $display("FAIL b2b_second got=%b/%h exp=1/22", bus.aux_rvalid, bus.aux_rdata); end
        step();
        set_idle();
        @(negedge clk);
        checks++; if (bus.aux_rvalid !== 1'b0) begin failures++; $display("FAIL store_no_rvalid got=%b exp=0", bus.aux_rvalid); end
        checks++; if (ram[10'h050] !== 8'h77) begin failures++; $display("FAIL aux_store_ram got=%h exp=77", ram[10'h050]); end
        step();
    endtask

    task automatic test_starvation();
        logic exp_gnt;
        logic exp_stall;
        set_idle();
        bus.core_en_load = 1'b1; bus.core_addr = 10'h005;
        bus.aux_req = 1'b1; bus.aux_we = 1'b1; bus.aux_addr = 10'h020; bus.aux_wdata = 8'h5A;
        for (int c = 1; c <= 7; c++) begin
            exp_gnt   = (c == 5 || c == 6);
            exp_stall = exp_gnt;
            @(negedge clk);
            checks++; if (bus.aux_gnt !== exp_gnt) begin failures++; $display("FAIL starve_gnt cyc=%0d got=%b exp=%b", c, bus.aux_gnt, exp_gnt); end
            checks++; if (bus.core_stall !== exp_stall) begin failures++; $display("FAIL starve_stall cyc=%0d got=%b exp=%b", c, bus.core_stall, exp_stall); end
            if (exp_gnt) begin
                checks++; if (bus.mem_en_store !== 1'b1 || bus.mem_en_load !== 1'b0 || bus.mem_addr !== 10'h020) begin
                    failures++; $display("FAIL starve_bus cyc=%0d got=%b%b/%h exp=01/020", c, bus.mem_en_load, bus.mem_en_store, bus.mem_addr);
                end
            end
            step();
        end
        set_idle();
        step();
    endtask

    task automatic test_reset_mid_burst();
        logic exp_gnt;
        set_idle();
        bus.core_en_load = 1'b1; bus.core_addr = 10'h005;
        bus.aux_req = 1'b1; bus.aux_we = 1'b0; bus.aux_addr = 10'h010;
        for (int c = 1; c <= 4; c++) step();
        @(negedge clk);
        checks++; if (bus.core_stall !== 1'b1 || bus.aux_gnt !== 1'b1) begin failures++; $display("FAIL midrst_forced got=%b/%b exp=1/1", bus.core_stall, bus.aux_gnt); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.core_stall !== 1'b0) begin failures++; $display("FAIL midrst_stall got=%b exp=0", bus.core_stall); end
        checks++; if (bus.aux_gnt !== 1'b0) begin failures++; $display("FAIL midrst_gnt got=%b exp=0", bus.aux_gnt); end
        checks++; if (bus.aux_rvalid !== 1'b0) begin failures++; $display("FAIL midrst_rvalid got=%b exp=0", bus.aux_rvalid); end
        step();
        // Starvation count restarted: three more blocked cycles, then forced.
        for (int c = 7; c <= 10; c++) begin
            exp_gnt = (c == 10);
            @(negedge clk);
            checks++; if (bus.aux_gnt !== exp_gnt || bus.core_stall !== exp_gnt) begin
                failures++; $display("FAIL midrst_restart cyc=%0d got=%b/%b exp=%b/%b", c, bus.aux_gnt, bus.core_stall, exp_gnt, exp_gnt);
            end
            step();
        end
        set_idle();
        step();
        step();
    endtask

    task automatic test_protect();
        set_idle();
        bus.aux_req = 1'b1; bus.aux_we = 1'b1; bus.aux_addr = 10'h300; bus.aux_wdata = 8'h99;
        @(negedge clk);
        checks++; if (bus.aux_gnt !== 1'b1) begin failures++; $display("FAIL prot_gnt got=%b exp=1", bus.aux_gnt); end
`ifdef DMEM_ARB_PROTECT_EN
        checks++; if (bus.mem_en_store !== 1'b0) begin failures++; $display("FAIL prot_block got=%b exp=0", bus.mem_en_store); end
`else
        checks++; if (bus.mem_en_store !== 1'b1) begin failures++; $display("FAIL prot_off_store got=%b exp=1", bus.mem_en_store); end
`endif
        step();
        bus.aux_addr = 10'h2FF; bus.aux_wdata = 8'h66;
        @(negedge clk);
`ifdef DMEM_ARB_PROTECT_EN
        checks++; if (bus.aux_err !== 1'b1) begin failures++; $display("FAIL prot_err got=%b exp=1", bus.aux_err); end
`else
        checks++; if (bus.aux_err !== 1'b0) begin failures++; $display("FAIL prot_off_err got=%b exp=0", bus.aux_err); end
`endif
        checks++; if (bus.mem_en_store !== 1'b1) begin failures++; $display("FAIL prot_below_store got=%b exp=1", bus.mem_en_store); end
        step();
        set_idle();
        @(negedge clk);
        checks++; if (bus.aux_err !== 1'b0) begin failures++; $display("FAIL prot_err_clear got=%b exp=0", bus.aux_err); end
        step();
    endtask

    // Reference: aux waits while the core is busy; after STARVE_MAX blocked
    // cycles it owns the port for up to BURST_MAX cycles (ends early if aux drops).
    task automatic test_random();
        int starve = 0;
        int forced_left = 0;
        logic pend_rv = 1'b0;
        logic pend_err = 1'b0;
        logic [7:0] pend_rd = 8'h00;
        logic e_stall, e_gnt, e_aux, e_eld, e_est, e_blk, core_act;
        logic [9:0] e_addr;
        logic [7:0] e_st;
        int r;
        rst = 1'b1;
        set_idle();
        step();
        rst = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            r = $urandom_range(0, 9);
            bus.core_en_load  = (r < 3) || (r == 5);
            bus.core_en_store = (r >= 3 && r <= 5);
            bus.core_addr     = 10'($urandom);
            bus.core_store    = 8'($urandom);
            if (!bus.aux_req && $urandom_range(0, 2) != 0) begin
                bus.aux_req   = 1'b1;
                bus.aux_we    = 1'($urandom);
                bus.aux_addr  = 10'($urandom);
                bus.aux_wdata = 8'($urandom);
            end
            @(negedge clk);
            core_act = bus.core_en_load | bus.core_en_store;
`ifdef DMEM_ARB_PROTECT_EN
            e_blk = bus.aux_we && (bus.aux_addr >= PROT_BASE);
`else
            e_blk = 1'b0;
`endif
            e_stall = (forced_left > 0);
            e_aux   = e_stall || (!core_act && bus.aux_req);
            e_gnt   = e_aux && bus.aux_req;
            e_eld   = e_aux ? (bus.aux_req && !bus.aux_we) : bus.core_en_load;
            e_est   = e_aux ? (bus.aux_req && bus.aux_we && !e_blk) : bus.core_en_store;
            e_addr  = e_aux ? bus.aux_addr : bus.core_addr;
            e_st    = e_aux ? bus.aux_wdata : bus.core_store;
            checks++; if (bus.core_stall !== e_stall || bus.aux_gnt !== e_gnt) begin
                failures++; $display("FAIL rnd_arb cyc=%0d got=%b/%b exp=%b/%b", cyc, bus.core_stall, bus.aux_gnt, e_stall, e_gnt);
            end
            checks++; if (bus.mem_en_load !== e_eld || bus.mem_en_store !== e_est || bus.mem_addr !== e_addr || bus.mem_store !== e_st) begin
                failures++; $display("FAIL rnd_bus cyc=%0d got=%b%b/%h/%h exp=%b%b/%h/%h", cyc, bus.mem_en_load, bus.mem_en_store, bus.mem_addr, bus.mem_store, e_eld, e_est, e_addr, e_st);
            end
            checks++; if (bus.aux_rvalid !== pend_rv || (pend_rv && bus.aux_rdata !== pend_rd)) begin
                failures++; $display("FAIL rnd_rdata cyc=%0d got=%b/%h exp=%b/%h", cyc, bus.aux_rvalid, bus.aux_rdata, pend_rv, pend_rd);
            end
            checks++; if (bus.aux_err !== pend_err) begin
                failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, bus.aux_err, pend_err);
            end
            pend_rv  = e_gnt && !bus.aux_we;
            pend_rd  = ram[bus.aux_addr];
            pend_err = e_gnt && bus.aux_we && e_blk;
            if (forced_left > 0) begin
                forced_left = (bus.aux_req && forced_left > 1) ? forced_left - 1 : 0;
                starve = 0;
            end else if (core_act && bus.aux_req) begin
                starve++;
                if (starve == STARVE_MAX) begin
                    forced_left = BURST_MAX;
                    starve = 0;
                end
            end else begin
                starve = 0;
            end
            step();
            if (e_gnt) bus.aux_req = 1'b0;
        end
        set_idle();
        step();
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        test_reset();
        test_core_only();
        test_opportunistic();
        test_back_to_back();
        test_starvation();
        test_reset_mid_burst();
        test_protect();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
